// File: rtl/qtcore_scan_sequencer.sv
// Host-facing byte sequencer for the qtcore scan chain: full-chain exchange (XCHG)
// and bounded RUN with halt detection. Scan shifting and proc_en are mutually exclusive.
module qtcore_scan_sequencer #(
    parameter int CHAIN_LEN = 168,
    parameter int MAX_RUN   = 256,
    parameter int MIN_RUN   = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cmd_valid_in,
    input  logic       cmd_op_in,
    output logic       cmd_ready_out,
    input  logic       wr_valid_in,
    input  logic [7:0] wr_data_in,
    output logic       wr_ready_out,
    output logic       rd_valid_out,
    output logic [7:0] rd_data_out,
    input  logic       rd_ready_in,
    output logic       scan_enable_out,
    output logic       scan_data_out,
    input  logic       scan_data_in,
    output logic       proc_en_out,
    input  logic       halt_in,
    output logic       busy_out,
    output logic [8:0] run_cycles_out,
    output logic       timeout_out
);
    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [8:0]    MAX_C     = 9'(MAX_RUN);
    localparam logic [8:0]    MIN_C     = 9'(MIN_RUN);

    typedef enum logic [2:0] {S_IDLE, S_XLOAD, S_XSHIFT, S_XPUSH, S_RUN} state_t;

    state_t          r_state;
    logic            r_cmd_ready, r_wr_ready, r_scan_en, r_rd_valid, r_busy, r_run;
    logic [BW-1:0]   r_byte_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_sreg;
    logic [8:0]      r_count;
    logic [8:0]      r_run_cycles;
    logic            r_timeout;
    logic            w_halt_ok, w_run_exit;

    // Exit is decided on the current count, so proc_en is already low in the exit cycle.
    assign w_halt_ok  = (r_count >= MIN_C) && halt_in;
    assign w_run_exit = r_run && (w_halt_ok || (r_count == MAX_C));

    assign cmd_ready_out   = r_cmd_ready;
    assign wr_ready_out    = r_wr_ready;
    assign rd_valid_out    = r_rd_valid;
    assign rd_data_out     = r_sreg;
    assign scan_enable_out = r_scan_en;
    assign scan_data_out   = r_scan_en & r_sreg[7];
    assign proc_en_out     = r_run & ~w_run_exit;
    assign busy_out        = r_busy;
    assign run_cycles_out  = r_run_cycles;
    assign timeout_out     = r_timeout;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b1;
            r_wr_ready   <= 1'b0;
            r_scan_en    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_run        <= 1'b0;
            r_byte_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_sreg       <= '0;
            r_count      <= '0;
            r_run_cycles <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_in && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_op_in) begin
                            r_state   <= S_RUN;
                            r_run     <= 1'b1;
                            r_count   <= '0;
                            r_timeout <= 1'b0;
                        end else begin
                            r_state    <= S_XLOAD;
                            r_wr_ready <= 1'b1;
                            r_byte_cnt <= LAST_BYTE;
                        end
                    end
                end
                S_XLOAD: begin
                    if (wr_valid_in) begin
                        r_sreg     <= wr_data_in;
                        r_bit_cnt  <= 3'd7;
                        r_wr_ready <= 1'b0;
                        r_scan_en  <= 1'b1;
                        r_state    <= S_XSHIFT;
                    end
                end
                S_XSHIFT: begin
                    // Outgoing MSB feeds the chain; the chain's output bit enters at the LSB.
                    r_sreg    <= {r_sreg[6:0], scan_data_in};
                    r_bit_cnt <= r_bit_cnt - 3'd1;
                    if (r_bit_cnt == 3'd0) begin
                        r_scan_en  <= 1'b0;
                        r_rd_valid <= 1'b1;
                        r_state    <= S_XPUSH;
                    end
                end
                S_XPUSH: begin
                    if (rd_ready_in) begin
                        r_rd_valid <= 1'b0;
                        if (r_byte_cnt == '0) begin
                            r_state     <= S_IDLE;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt - 1'b1;
                            r_wr_ready <= 1'b1;
                            r_state    <= S_XLOAD;
                        end
                    end
                end
                S_RUN: begin
                    if (w_run_exit) begin
                        r_run        <= 1'b0;
                        r_state      <= S_IDLE;
                        r_cmd_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_run_cycles <= r_count;
                        r_timeout    <= ~w_halt_ok;
                    end else begin
                        r_count <= r_count + 9'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_wr_ready  <= 1'b0;
                    r_scan_en   <= 1'b0;
                    r_rd_valid  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_run       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// Bench for qtcore_scan_sequencer: a behavioural scan-chain core plus a byte-level
// exchange/run reference model, with random stalls, command noise and resets.
module tb_qtcore_scan_sequencer;
    localparam int CL     = 168;
    localparam int NB     = CL / 8;
    localparam int MAXR   = 256;
    localparam int MINR   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_op = 1'b0;
    logic       cmd_ready;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       scan_en, scan_do, scan_di, proc_en, halt = 1'b0, busy, tmo_out;
    logic [8:0] run_cycles;

    int n_cmp = 0, n_err = 0;
    int shift_cnt = 0, overlap_cnt = 0;

    logic [CL-1:0] env_chain, env_seed, exp_chain;
    logic          env_load = 1'b1;

    qtcore_scan_sequencer #(.CHAIN_LEN(CL), .MAX_RUN(MAXR), .MIN_RUN(MINR)) dut (
        .clk_in(clk), .rst_in(rst),
        .cmd_valid_in(cmd_valid), .cmd_op_in(cmd_op), .cmd_ready_out(cmd_ready),
        .wr_valid_in(wr_valid), .wr_data_in(wr_data), .wr_ready_out(wr_ready),
        .rd_valid_out(rd_valid), .rd_data_out(rd_data), .rd_ready_in(rd_ready),
        .scan_enable_out(scan_en), .scan_data_out(scan_do), .scan_data_in(scan_di),
        .proc_en_out(proc_en), .halt_in(halt), .busy_out(busy),
        .run_cycles_out(run_cycles), .timeout_out(tmo_out)
    );

    always #5 clk = ~clk;

    // Core stand-in: a plain shift chain, MSB out, new bits enter at the LSB.
    assign scan_di = env_chain[CL-1];
    always @(posedge clk) begin
        if (env_load) env_chain <= env_seed;
        else if (scan_en) env_chain <= {env_chain[CL-2:0], scan_do};
        if (scan_en) shift_cnt <= shift_cnt + 1;
        if (scan_en && proc_en) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // After any reset: only cmd_ready high, run status cleared.
    task automatic check_idle(input string tag);
        check(tag, CL'({cmd_ready, busy, wr_ready, scan_en, rd_valid, proc_en, tmo_out, run_cycles}),
              CL'({1'b1, 6'b0, 9'd0}));
    endtask

    task automatic do_xchg(input logic [CL-1:0] img, input bit stall, input int abort_byte);
        logic [CL-1:0] rd_all, new_img;
        logic [7:0]    b;
        int            s0, t, stall_sh;
        rd_all = '0; new_img = '0; stall_sh = 0; s0 = shift_cnt;
        cmd_op = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            b = img[CL-1-8*i -: 8];
            if (stall) repeat ($urandom_range(0, 5)) begin
                if (scan_en) stall_sh++;
                cmd_valid = 1'($urandom); cmd_op = 1'($urandom);
                @(negedge clk);
            end
            t = 0;
            while (!wr_ready && t < 20) begin @(negedge clk); t++; end
            if (!wr_ready) begin check("wr_ready_wait", 0, 1); cmd_valid = 1'b0; return; end
            wr_valid = 1'b1; wr_data = b;
            @(negedge clk);
            wr_valid = 1'b0;
            if (i == abort_byte) begin
                repeat (3) @(negedge clk);
                rst = 1'b1; cmd_valid = 1'b0;
                @(negedge clk);
                check_idle("idle_after_xshift_reset");
                // Three completed shifts plus the one on the reset edge itself.
                check("shifts_before_abort", CL'(shift_cnt - s0), CL'(8 * abort_byte + 4));
                rst = 1'b0;
                exp_chain = env_chain;
                return;
            end
            t = 0;
            while (!rd_valid && t < 20) begin @(negedge clk); t++; end
            if (!rd_valid) begin check("rd_valid_wait", 0, 1); cmd_valid = 1'b0; return; end
            if (stall) repeat ($urandom_range(0, 5)) begin
                if (scan_en) stall_sh++;
                cmd_valid = 1'($urandom); cmd_op = 1'($urandom);
                @(negedge clk);
            end
            rd_all  = {rd_all[CL-9:0], rd_data};
            new_img = {new_img[CL-9:0], b};
            rd_ready = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
            @(negedge clk);
            rd_ready = 1'b0;
        end
        check("rd_stream", rd_all, exp_chain);
        check("shift_count", CL'(shift_cnt - s0), CL'(CL));
        check("stall_shifts", CL'(stall_sh), '0);
        check("chain_loaded", env_chain, new_img);
        check("xchg_done_idle", CL'({cmd_ready, busy}), CL'(2'b10));
        exp_chain = new_img;
    endtask

    task automatic do_run(input int h, input int abort_at);
        int pc, t, hh, exp_c;
        bit exp_to;
        cmd_op = 1'b1; cmd_valid = 1'b1; halt = (h <= 0);
        @(negedge clk);
        pc = 0; t = 0;
        while (t < 400) begin
            halt = (pc >= h);
            cmd_valid = 1'($urandom); cmd_op = 1'($urandom);
            #1;
            if (!busy) break;
            if (abort_at >= 0 && pc == abort_at) begin
                rst = 1'b1; cmd_valid = 1'b0;
                @(negedge clk);
                check_idle("idle_after_run_reset");
                rst = 1'b0; halt = 1'b0;
                return;
            end
            if (proc_en) pc++;
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0; cmd_op = 1'b0;
        if (t >= 400) check("run_wait", 0, 1);
        hh     = (h < MINR) ? MINR : h;
        exp_c  = (hh > MAXR) ? MAXR : hh;
        exp_to = (h > MAXR);
        check("run_cycles", CL'(run_cycles), CL'(exp_c));
        check("proc_en_cycles", CL'(pc), CL'(exp_c));
        check("timeout", CL'(tmo_out), CL'(exp_to));
        @(negedge clk);
        halt = 1'b0;
    endtask

    function automatic logic [CL-1:0] rand_img();
        logic [CL-1:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v = {v[CL-33:0], 32'($urandom)};
        return v;
    endfunction

    initial begin
        logic [CL-1:0] img1;
        img1 = {8'hF0, 8'hE0, 8'h01, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 80'h0, 24'h001010};
        env_seed = rand_img();
        exp_chain = env_seed;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        check("reset_rd_data", CL'(rd_data), '0);
        env_load = 1'b0; rst = 1'b0;
        @(negedge clk);

        do_xchg(img1, 1'b0, -1);
        do_run(10000, -1);
        do_xchg('0, 1'b1, -1);
        do_run(0, -1);
        do_run(37, -1);
        do_run(MAXR, -1);
        do_run(MAXR + 1, -1);
        for (int r = 0; r < 3; r++) begin
            do_xchg(rand_img(), 1'b1, -1);
            do_run(int'($urandom_range(0, 300)), -1);
        end
        do_xchg(rand_img(), 1'b1, 7);
        do_xchg(img1, 1'b1, -1);
        do_run(10000, 50);
        do_xchg(rand_img(), 1'b0, -1);
        do_xchg(rand_img(), 1'b1, -1);
        check("enable_overlap", CL'(overlap_cnt), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
